sr_latch_seq_ctrl: RTL and testbench

Sequencer that owns the set/reset pins of the external heat-enable sr_latch in the microwave control path. It turns start, stop, door and timer events into timed, non-overlapping S and R pulses, with dead time between them. After each pulse it checks the latch's Q feedback. The S=R=1 forbidden input is never presented to the latch, and the block fails safe (latch held reset) on a feedback mismatch.

---
 rtl/sr_latch_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sr_latch_seq_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_seq_ctrl.sv
// Sequencer driving the S/R pins of the external heat-enable latch: timed, non-overlapping
// pulses with dead time, Q feedback verification and a fail-safe hold-reset state.
module sr_latch_seq_ctrl #(
   parameter int PULSE_W = 4,
   parameter int DEAD_W  = 2,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_btn,
   input  logic stop_btn,
   input  logic door_open,
   input  logic timer_done,
   input  logic fault_clr,
   input  logic latch_q,
   output logic latch_s,
   output logic latch_r,
   output logic busy,
   output logic fault,
   output logic heat_on
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SET_P = 3'd1;
   localparam logic [2:0] ST_RST_P = 3'd2;
   localparam logic [2:0] ST_DEAD  = 3'd3;
   localparam logic [2:0] ST_CHECK = 3'd4;
   localparam logic [2:0] ST_FAULT = 3'd5;

   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_W - 1);
   localparam logic [CNT_W-1:0] CHECK_LOAD = CNT_W'(2);

   logic [2:0]       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             pending_rst, pending_n;
   logic             expect_q, expect_n;
   logic             latch_s_n, latch_r_n, fault_n;
   logic             q_meta, q_s;
   logic             start_d, stop_d, timer_d;
   logic             rise_start, rst_req, cnt_done;

   assign rise_start = start_btn & ~start_d;
   assign rst_req    = (stop_btn & ~stop_d) | (timer_done & ~timer_d) | door_open;
   assign cnt_done   = (cnt == '0);
   assign heat_on    = q_s;

   // Next-state logic; drive values are computed here so S and R come straight from flops.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      pending_n = pending_rst;
      expect_n  = expect_q;
      latch_s_n = 1'b0;
      latch_r_n = 1'b0;
      fault_n   = fault;
      case (state)
         ST_IDLE: begin
            if (rst_req && q_s) begin
               state_n   = ST_RST_P;
               cnt_n     = PULSE_LOAD;
               latch_r_n = 1'b1;
            end else if (rise_start && !door_open && !q_s) begin
               state_n   = ST_SET_P;
               cnt_n     = PULSE_LOAD;
               latch_s_n = 1'b1;
            end
         end
         ST_SET_P: begin
            if (rst_req) begin
               state_n   = ST_DEAD;
               cnt_n     = DEAD_LOAD;
               pending_n = 1'b1;
               expect_n  = 1'b1;
            end else if (cnt_done) begin
               state_n  = ST_DEAD;
               cnt_n    = DEAD_LOAD;
               expect_n = 1'b1;
            end else begin
               cnt_n     = cnt - 1'b1;
               latch_s_n = 1'b1;
            end
         end
         ST_RST_P: begin
            if (cnt_done) begin
               state_n  = ST_DEAD;
               cnt_n    = DEAD_LOAD;
               expect_n = 1'b0;
            end else begin
               cnt_n     = cnt - 1'b1;
               latch_r_n = 1'b1;
            end
         end
         ST_DEAD: begin
            if (rst_req && expect_q)
               pending_n = 1'b1;
            if (cnt_done) begin
               if (pending_n) begin
                  state_n   = ST_RST_P;
                  cnt_n     = PULSE_LOAD;
                  pending_n = 1'b0;
                  latch_r_n = 1'b1;
               end else begin
                  state_n = ST_CHECK;
                  cnt_n   = CHECK_LOAD;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         // Compare only after the synchronizer has had time to reflect the pulse.
         ST_CHECK: begin
            if (rst_req && expect_q)
               pending_n = 1'b1;
            if (cnt_done) begin
               if (q_s == expect_q) begin
                  if (pending_n) begin
                     state_n   = ST_RST_P;
                     cnt_n     = PULSE_LOAD;
                     pending_n = 1'b0;
                     latch_r_n = 1'b1;
                  end else begin
                     state_n = ST_IDLE;
                  end
               end else begin
                  state_n   = ST_FAULT;
                  pending_n = 1'b0;
                  fault_n   = 1'b1;
                  latch_r_n = 1'b1;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ST_FAULT: begin
            if (fault_clr) begin
               state_n   = ST_DEAD;
               cnt_n     = DEAD_LOAD;
               fault_n   = 1'b0;
               expect_n  = 1'b0;
               pending_n = 1'b0;
            end else begin
               latch_r_n = 1'b1;
            end
         end
         default: begin
            state_n   = ST_FAULT;
            fault_n   = 1'b1;
            latch_r_n = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         pending_rst <= 1'b0;
         expect_q    <= 1'b0;
         latch_s     <= 1'b0;
         latch_r     <= 1'b0;
         busy        <= 1'b0;
         fault       <= 1'b0;
         q_meta      <= 1'b0;
         q_s         <= 1'b0;
         start_d     <= 1'b0;
         stop_d      <= 1'b0;
         timer_d     <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         pending_rst <= pending_n;
         expect_q    <= expect_n;
         latch_s     <= latch_s_n;
         latch_r     <= latch_r_n;
         busy        <= (state_n != ST_IDLE);
         fault       <= fault_n;
         q_meta      <= latch_q;
         q_s         <= q_meta;
         start_d     <= start_btn;
         stop_d      <= stop_btn;
         timer_d     <= timer_done;
      end
   end

endmodule

// File: tb/tb_sr_latch_seq_ctrl.sv
// Scoreboard bench for sr_latch_seq_ctrl with a clocked model of the external SR latch.
module tb_sr_latch_seq_ctrl;

   localparam int PULSE_W = 4;
   localparam int DEAD_W  = 2;
   localparam int CNT_W   = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start_btn = 1'b0;
   logic stop_btn = 1'b0;
   logic door_open = 1'b0;
   logic timer_done = 1'b0;
   logic fault_clr = 1'b0;
   logic latch_q;
   logic latch_s, latch_r, busy, fault, heat_on;

   logic model_q = 1'b0;
   logic q_stuck0 = 1'b0;

   int errors = 0;
   int checks = 0;

   // Per-cycle expected {latch_s, latch_r, busy, fault}
   logic [3:0] exp_q[$];
   logic [3:0] exp_v, obs_v;

   always #5 clk = ~clk;

   // External latch: follows S/R one edge later, optionally stuck at 0
   always @(posedge clk) begin
      if (q_stuck0)
         model_q <= 1'b0;
      else if (latch_s)
         model_q <= 1'b1;
      else if (latch_r)
         model_q <= 1'b0;
   end
   assign latch_q = model_q;

   sr_latch_seq_ctrl #(
      .PULSE_W(PULSE_W),
      .DEAD_W (DEAD_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_btn (start_btn),
      .stop_btn  (stop_btn),
      .door_open (door_open),
      .timer_done(timer_done),
      .fault_clr (fault_clr),
      .latch_q   (latch_q),
      .latch_s   (latch_s),
      .latch_r   (latch_r),
      .busy      (busy),
      .fault     (fault),
      .heat_on   (heat_on)
   );

   task automatic push_n(input logic [3:0] v, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(v);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({latch_s, latch_r, busy, fault, heat_on} !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL reset_state: got %b want 00000", {latch_s, latch_r, busy, fault, heat_on});
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_set_path();
      int n;
      @(posedge clk); #1 start_btn = 1'b1;
      push_n(4'b1010, PULSE_W);
      push_n(4'b0010, DEAD_W + 3);
      push_n(4'b0000, 1);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         obs_v = {latch_s, latch_r, busy, fault};
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL set_path cycle %0d: got %b want %b", i, obs_v, exp_v);
         end
         if (i == 0) start_btn = 1'b0;
      end
      checks++;
      if (heat_on !== 1'b1) begin
         errors++;
         $display("[TB] FAIL set_path_heat_on: got %b want 1", heat_on);
      end
   endtask

   task automatic test_stop();
      int n;
      @(posedge clk); #1 stop_btn = 1'b1;
      push_n(4'b0110, PULSE_W);
      push_n(4'b0010, DEAD_W + 3);
      push_n(4'b0000, 1);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         obs_v = {latch_s, latch_r, busy, fault};
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL stop cycle %0d: got %b want %b", i, obs_v, exp_v);
         end
         if (i == 0) stop_btn = 1'b0;
      end
      checks++;
      if (heat_on !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stop_heat_on: got %b want 0", heat_on);
      end
   endtask

   task automatic test_abort_mid_set();
      int n;
      @(posedge clk); #1 start_btn = 1'b1;
      push_n(4'b1010, 2);
      push_n(4'b0010, DEAD_W);
      push_n(4'b0110, PULSE_W);
      push_n(4'b0010, DEAD_W + 3);
      push_n(4'b0000, 1);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         obs_v = {latch_s, latch_r, busy, fault};
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL abort_mid_set cycle %0d: got %b want %b", i, obs_v, exp_v);
         end
         if (i == 0) start_btn = 1'b0;
         if (i == 1) door_open = 1'b1;
      end
      checks++;
      if (heat_on !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_heat_on: got %b want 0", heat_on);
      end
      door_open = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_start_blocked();
      int n;
      @(posedge clk); #1 door_open = 1'b1;
      push_n(4'b0000, 12);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         obs_v = {latch_s, latch_r, busy, fault};
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL start_blocked cycle %0d: got %b want %b", i, obs_v, exp_v);
         end
         start_btn = (i % 3 == 0);
      end
      start_btn = 1'b0;
      door_open = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_simultaneous();
      int n;
      test_set_path();
      @(posedge clk); #1;
      start_btn = 1'b1;
      stop_btn  = 1'b1;
      push_n(4'b0110, PULSE_W);
      push_n(4'b0010, DEAD_W + 3);
      push_n(4'b0000, 1);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         obs_v = {latch_s, latch_r, busy, fault};
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL simultaneous cycle %0d: got %b want %b", i, obs_v, exp_v);
         end
         if (i == 0) begin
            start_btn = 1'b0;
            stop_btn  = 1'b0;
         end
      end
      checks++;
      if (heat_on !== 1'b0) begin
         errors++;
         $display("[TB] FAIL simultaneous_heat_on: got %b want 0", heat_on);
      end
   endtask

   task automatic test_fault();
      int n;
      q_stuck0 = 1'b1;
      @(posedge clk); #1 start_btn = 1'b1;
      push_n(4'b1010, PULSE_W);
      push_n(4'b0010, DEAD_W + 3);
      push_n(4'b0111, 3);
      push_n(4'b0010, DEAD_W + 3);
      push_n(4'b0000, 1);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         obs_v = {latch_s, latch_r, busy, fault};
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL fault cycle %0d: got %b want %b", i, obs_v, exp_v);
         end
         if (i == 0) start_btn = 1'b0;
         if (i == PULSE_W + DEAD_W + 5) fault_clr = 1'b1;
         if (i == PULSE_W + DEAD_W + 6) fault_clr = 1'b0;
      end
      q_stuck0 = 1'b0;
   endtask

   task automatic test_async_reset();
      test_set_path();
      @(posedge clk); #1 stop_btn = 1'b1;
      @(posedge clk); #1 stop_btn = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (latch_r !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pre_reset_latch_r: got %b want 1", latch_r);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({latch_s, latch_r, busy} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL async_clear: got %b want 000", {latch_s, latch_r, busy});
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({latch_s, latch_r, busy, fault, heat_on} !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL after_reset: got %b want 00000", {latch_s, latch_r, busy, fault, heat_on});
      end
   endtask

   task automatic test_random_invariant();
      int viol = 0;
      int set_seen = 0;
      for (int c = 0; c < 10000; c++) begin
         @(posedge clk); #1;
         if (latch_s && latch_r) viol++;
         if (latch_s) set_seen++;
         start_btn  = ($urandom_range(0, 7) == 0);
         stop_btn   = ($urandom_range(0, 15) == 0);
         timer_done = ($urandom_range(0, 15) == 0);
         fault_clr  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 31) == 0) door_open = ~door_open;
         if ($urandom_range(0, 255) == 0) q_stuck0 = ~q_stuck0;
         rst_n = ($urandom_range(0, 999) != 0);
         @(negedge clk);
         if (latch_s && latch_r) viol++;
      end
      start_btn  = 1'b0;
      stop_btn   = 1'b0;
      timer_done = 1'b0;
      fault_clr  = 1'b0;
      door_open  = 1'b0;
      q_stuck0   = 1'b0;
      rst_n      = 1'b1;
      checks++;
      if (viol != 0) begin
         errors++;
         $display("[TB] FAIL random_s_and_r: got %0d overlap samples want 0", viol);
      end
      checks++;
      if (set_seen == 0) begin
         errors++;
         $display("[TB] FAIL random_set_activity: got %0d set cycles want >0", set_seen);
      end
   endtask

   initial begin
      $display("[TB] starting sr_latch_seq_ctrl bench");
      test_reset();
      test_set_path();
      test_stop();
      test_abort_mid_set();
      test_start_blocked();
      test_simultaneous();
      test_fault();
      test_async_reset();
      test_random_invariant();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
